segment_transition_ctl: RTL and testbench

SEGMENT_TRANSITION_CTL -- requirements
Module: segment_transition_ctl

---
 rtl/segment_transition_ctl.sv | 103 ++++++++++
 tb/tb_segment_transition_ctl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/segment_transition_ctl.sv
// segment_transition_ctl: arms a read-segment switch and fires it on a loop end, a time match, a GPIO edge or every loop end in EXT mode
// Ports: CLK/RST_N clock and async active-low reset; UPDATE with REQ_SEGMENT, TRANSITION_MODE and TRANSITION_VALUE
// loads a new request; SYS_TIME, LOOP_END and GPIO_IN are the trigger sources; SEGMENT, SWITCH, PENDING and ERR_MODE
// are all registered.
module segment_transition_ctl #(
  parameter int SysTimeWidth = 64
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    UPDATE,
  input  logic                    REQ_SEGMENT,
  input  logic [7:0]              TRANSITION_MODE,
  input  logic [SysTimeWidth-1:0] TRANSITION_VALUE,
  input  logic [SysTimeWidth-1:0] SYS_TIME,
  input  logic                    LOOP_END,
  input  logic [3:0]              GPIO_IN,
  output logic                    SEGMENT,
  output logic                    SWITCH,
  output logic                    PENDING,
  output logic                    ERR_MODE
);
  localparam logic [7:0] M_SYNC = 8'h00;
  localparam logic [7:0] M_TIME = 8'h01;
  localparam logic [7:0] M_GPIO = 8'h02;
  localparam logic [7:0] M_EXT  = 8'hF0;
  typedef enum logic [2:0] {IDLE, WAIT_SYNC, WAIT_TIME, WAIT_GPIO, EXT} state_e;
  state_e state_q, state_d;
  logic seg_q, seg_d, sw_q, sw_d, pend_q, pend_d, err_q, err_d, rseg_q, rseg_d;
  logic [7:0] mode_q, mode_d;
  logic [SysTimeWidth-1:0] val_q, val_d;
  logic [3:0] gpio_q;
  logic gpio_rise, trig, same;
  assign gpio_rise = GPIO_IN[val_q[1:0]] & ~gpio_q[val_q[1:0]];
  // the latched mode picks which event fires an armed wait
  assign trig = mode_q == M_SYNC ? LOOP_END :
                mode_q == M_TIME ? SYS_TIME >= val_q :
                mode_q == M_GPIO ? gpio_rise : 1'b0;
  assign same = REQ_SEGMENT == seg_q;
  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    sw_d    = 1'b0;
    err_d   = err_q;
    rseg_d  = rseg_q;
    mode_d  = mode_q;
    val_d   = val_q;
    if (UPDATE) begin
      rseg_d = REQ_SEGMENT;
      mode_d = TRANSITION_MODE;
      val_d  = TRANSITION_VALUE;
      err_d  = 1'b0;
      case (TRANSITION_MODE)
        M_SYNC: state_d = same ? IDLE : WAIT_SYNC;
        M_TIME: state_d = same ? IDLE : WAIT_TIME;
        M_GPIO: state_d = same ? IDLE : WAIT_GPIO;
        M_EXT: begin
          state_d = EXT;
          seg_d   = REQ_SEGMENT;
          sw_d    = ~same;
        end
        default: begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      endcase
    end else if (pend_q && trig) begin
      seg_d   = rseg_q;
      sw_d    = 1'b1;
      state_d = IDLE;
    end else if (state_q == EXT && LOOP_END) begin
      seg_d = ~seg_q;
      sw_d  = 1'b1;
    end
    pend_d = state_d inside {WAIT_SYNC, WAIT_TIME, WAIT_GPIO};
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      seg_q   <= 1'b0;
      sw_q    <= 1'b0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      rseg_q  <= 1'b0;
      mode_q  <= '0;
      val_q   <= '0;
      gpio_q  <= '0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      sw_q    <= sw_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      rseg_q  <= rseg_d;
      mode_q  <= mode_d;
      val_q   <= val_d;
      gpio_q  <= GPIO_IN;
    end
  end
  assign SEGMENT  = seg_q;
  assign SWITCH   = sw_q;
  assign PENDING  = pend_q;
  assign ERR_MODE = err_q;
endmodule

// File: tb/tb_segment_transition_ctl.sv
// tb_segment_transition_ctl: directed and randomized checks of segment_transition_ctl against a request-level model
module tb_segment_transition_ctl;
  logic clk = 1'b0, rst_n = 1'b0, upd = 1'b0, rs = 1'b0, le = 1'b0;
  logic [7:0] mode = '0;
  logic [63:0] val = '0, st = '0;
  logic [3:0] gpio = '0;
  logic seg, sw, pend, err;
  int tests = 0, fails = 0;
  segment_transition_ctl #(.SysTimeWidth(64)) dut (
    .CLK(clk), .RST_N(rst_n), .UPDATE(upd), .REQ_SEGMENT(rs), .TRANSITION_MODE(mode),
    .TRANSITION_VALUE(val), .SYS_TIME(st), .LOOP_END(le), .GPIO_IN(gpio),
    .SEGMENT(seg), .SWITCH(sw), .PENDING(pend), .ERR_MODE(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic a, input logic e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s at %0t: got %b expected %b", n, $time, a, e);
    end
  endtask
  // armed: 0 nothing, 1 loop end, 2 time, 3 gpio edge, 4 ext toggling
  int armed = 0;
  logic m_seg = 0, m_sw = 0, m_pend = 0, m_err = 0, m_tseg = 0;
  logic [63:0] m_val = '0;
  logic [3:0] m_prevg = '0;
  task automatic model_step();
    logic fire;
    if (!rst_n) begin
      armed = 0; m_seg = 0; m_sw = 0; m_pend = 0; m_err = 0; m_tseg = 0; m_val = '0; m_prevg = '0;
      return;
    end
    m_sw = 0;
    if (upd) begin
      m_err = 0; m_tseg = rs; m_val = val;
      if (mode == 8'h00 || mode == 8'h01 || mode == 8'h02) armed = (rs == m_seg) ? 0 : int'(mode) + 1;
      else if (mode == 8'hF0) begin
        armed = 4;
        if (rs != m_seg) begin m_seg = rs; m_sw = 1; end
      end else begin
        armed = 0; m_err = 1;
      end
    end else begin
      fire = (armed == 1 && le) || (armed == 2 && st >= m_val) ||
             (armed == 3 && gpio[m_val[1:0]] && !m_prevg[m_val[1:0]]);
      if (fire) begin m_seg = m_tseg; m_sw = 1; armed = 0; end
      else if (armed == 4 && le) begin m_seg = !m_seg; m_sw = 1; end
    end
    m_pend = armed >= 1 && armed <= 3;
    m_prevg = gpio;
  endtask
  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end
  initial forever begin
    @(posedge clk);
    #1;
    chk("seg", seg, m_seg);
    chk("switch", sw, m_sw);
    chk("pending", pend, m_pend);
    chk("err", err, m_err);
  end
  task automatic cyc();
    @(negedge clk);
    upd = 0;
    le = 0;
  endtask
  task automatic req(input logic s, input logic [7:0] m, input logic [63:0] v);
    upd = 1; rs = s; mode = m; val = v;
  endtask
  initial begin
    repeat (2) cyc();
    chk("rst_seg", seg, 0); chk("rst_sw", sw, 0); chk("rst_pend", pend, 0); chk("rst_err", err, 0);
    rst_n = 1;
    cyc();
    req(1, 8'h00, 0);
    repeat (10) begin cyc(); chk("sync_wait_pend", pend, 1); chk("sync_wait_seg", seg, 0); end
    le = 1;
    cyc(); chk("sync_seg", seg, 1); chk("sync_sw", sw, 1); chk("sync_pend", pend, 0);
    cyc(); chk("sync_sw_end", sw, 0);
    st = 100;
    req(0, 8'h01, 105);
    for (int s = 101; s <= 105; s++) begin cyc(); chk("time_wait_seg", seg, 1); st = 64'(s); end
    cyc(); chk("time_seg", seg, 0); chk("time_sw", sw, 1);
    req(1, 8'h01, 50);
    cyc(); chk("past_pend", pend, 1); chk("past_sw0", sw, 0);
    cyc(); chk("past_seg", seg, 1); chk("past_sw", sw, 1);
    gpio = 4'b0100;
    req(0, 8'h02, 2);
    repeat (3) begin cyc(); chk("gpio_hi_sw", sw, 0); chk("gpio_hi_seg", seg, 1); end
    gpio = 4'b0000;
    cyc(); chk("gpio_lo_seg", seg, 1);
    gpio = 4'b0100;
    cyc(); chk("gpio_seg", seg, 0); chk("gpio_sw", sw, 1); chk("gpio_pend", pend, 0);
    req(1, 8'hF0, 0);
    cyc(); chk("ext_seg0", seg, 1); chk("ext_sw0", sw, 1); chk("ext_pend", pend, 0);
    cyc(); chk("ext_gap", sw, 0);
    le = 1; cyc(); chk("ext_seg1", seg, 0); chk("ext_sw1", sw, 1);
    le = 1; cyc(); chk("ext_seg2", seg, 1); chk("ext_sw2", sw, 1);
    le = 1; cyc(); chk("ext_seg3", seg, 0); chk("ext_sw3", sw, 1);
    req(0, 8'h00, 0); le = 1;
    cyc(); chk("ext_prio_seg", seg, 0); chk("ext_prio_sw", sw, 0); chk("ext_prio_pend", pend, 0);
    req(1, 8'h07, 0);
    cyc(); chk("err_set", err, 1); chk("err_seg", seg, 0);
    cyc(); chk("err_sticky", err, 1);
    req(0, 8'h00, 0);
    cyc(); chk("err_clr", err, 0);
    req(1, 8'h00, 0);
    cyc(); chk("rst_arm_pend", pend, 1);
    rst_n = 0;
    cyc(); chk("rst_mid_pend", pend, 0);
    rst_n = 1;
    cyc(); le = 1;
    cyc(); chk("rst_le_seg", seg, 0); chk("rst_le_sw", sw, 0); chk("rst_le_pend", pend, 0);
    st = 200;
    for (int i = 0; i < 3000; i++) begin
      int r;
      cyc();
      r = int'($urandom_range(0, 9));
      upd = $urandom_range(0, 7) == 0;
      rs = 1'($urandom_range(0, 1));
      mode = r < 2 ? 8'h00 : r < 4 ? 8'h01 : r < 6 ? 8'h02 : r < 8 ? 8'hF0 : 8'($urandom_range(0, 255));
      val = mode == 8'h01 ? st + 64'($urandom_range(0, 30)) - 64'd8 : {$urandom, $urandom};
      le = $urandom_range(0, 5) == 0;
      if ($urandom_range(0, 3) == 0) gpio = 4'($urandom_range(0, 15));
      st = st + 64'($urandom_range(0, 2));
      rst_n = $urandom_range(0, 299) != 0;
    end
    cyc();
    rst_n = 1;
    cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
